// File: rtl/spi_slave.sv
// spi_slave: SPI command bridge that issues TCM reads/writes and releases the core
module spi_slave #(
    parameter int FRAME_BITS = 72
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk,
    input  logic        cs,
    input  logic        mosi,
    output logic        miso,
    output logic        start_flag,
    input  logic [31:0] data_rd_i,
    input  logic        mem_accept,
    input  logic        mem_ack,
    output logic        data_rd_en_o,
    output logic [31:0] data_adr_o,
    output logic [31:0] data_wr_o,
    output logic [3:0]  data_wr_en_o
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] REQ      = 2'd1;
    localparam logic [1:0] WAIT_ACK = 2'd2;

    logic [2:0]            sclk_q;
    logic [1:0]            cs_q, mosi_q;
    logic [FRAME_BITS-1:0] rx, tx, pend_frame, new_frame, ex;
    logic [6:0]            cnt;
    logic [1:0]            state;
    logic                  pend, is_rd, rise, fall, sel, done, ex_go, is_mem;
    logic [7:0]            cmd;

    assign rise      = sclk_q[1] & ~sclk_q[2];
    assign fall      = ~sclk_q[1] & sclk_q[2];
    assign sel       = ~cs_q[1];
    assign new_frame = {mosi_q[1], rx[FRAME_BITS-1:1]};
    assign done      = rise & sel & (cnt == 7'(FRAME_BITS - 1));
    assign ex_go     = (state == IDLE) & (pend | done);
    assign ex        = pend ? pend_frame : new_frame;
    assign cmd       = ex[FRAME_BITS-1 -: 8];
    assign is_mem    = (cmd == 8'hF0) | (cmd == 8'h0F);
    assign miso      = tx[FRAME_BITS-1];

    // Pin synchronizers; sclk keeps a third stage for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q <= '0;
            cs_q   <= '1;
            mosi_q <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], sclk};
            cs_q   <= {cs_q[0], cs};
            mosi_q <= {mosi_q[0], mosi};
        end
    end

    // LSB-first receive shifter and bit counter; cs high discards a partial frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx  <= '0;
            cnt <= '0;
        end else if (!sel) begin
            cnt <= '0;
        end else if (rise) begin
            rx  <= new_frame;
            cnt <= done ? 7'd0 : cnt + 7'd1;
        end
    end

    // One-deep queue for frames that complete while a transaction is in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend       <= 1'b0;
            pend_frame <= '0;
        end else if (done && !(state == IDLE && !pend)) begin
            pend       <= 1'b1;
            pend_frame <= new_frame;
        end else if (state == IDLE) begin
            pend <= 1'b0;
        end
    end

    // Memory request FSM; enables drop on accept, completion waits for ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            is_rd        <= 1'b0;
            start_flag   <= 1'b0;
            data_rd_en_o <= 1'b0;
            data_wr_en_o <= '0;
            data_adr_o   <= '0;
            data_wr_o    <= '0;
        end else if (state == IDLE) begin
            if (ex_go && cmd == 8'hFF) start_flag <= 1'b1;
            if (ex_go && is_mem) begin
                state        <= REQ;
                is_rd        <= cmd == 8'h0F;
                data_rd_en_o <= cmd == 8'h0F;
                data_adr_o   <= ex[63:32];
                if (cmd == 8'hF0) begin
                    data_wr_o    <= ex[31:0];
                    data_wr_en_o <= 4'hF;
                end
            end
        end else if (state == REQ) begin
            if (mem_accept) begin
                state        <= WAIT_ACK;
                data_rd_en_o <= 1'b0;
                data_wr_en_o <= '0;
            end
        end else if (mem_ack) begin
            state <= IDLE;
        end
    end

    // MSB-first transmit register; the fall after a frame's last bit is not shifted so a fresh response survives
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tx <= '0;
        else if (state == WAIT_ACK && mem_ack)
            tx <= {is_rd ? 8'h0F : 8'hF0, data_adr_o, is_rd ? data_rd_i : data_wr_o};
        else if (ex_go && !is_mem) tx <= (cmd == 8'hFF) ? ex : '0;
        else if (fall && sel && |cnt) tx <= tx << 1;
    end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: randomized SPI host with TCM stub, reference model and scoreboard
module tb_spi_slave;
    localparam int H = 80;

    logic        clk = 0, rst = 1, sclk = 0, cs = 1, mosi = 0;
    logic        miso, start_flag, data_rd_en_o;
    logic [31:0] data_rd_i = 0, data_adr_o, data_wr_o;
    logic        mem_accept = 0, mem_ack = 0;
    logic [3:0]  data_wr_en_o;

    int checks = 0, passed = 0, reqs = 0;
    logic [71:0] exp_q[$], cap_q[$];
    logic [31:0] tcm[logic [31:0]];
    logic [31:0] ref_mem[logic [31:0]];
    logic [71:0] cur_tx = 0;
    logic        start_exp = 0, ack_due = 0;
    logic [31:0] ack_adr = 0;

    spi_slave dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
        .start_flag(start_flag), .data_rd_i(data_rd_i), .mem_accept(mem_accept),
        .mem_ack(mem_ack), .data_rd_en_o(data_rd_en_o), .data_adr_o(data_adr_o),
        .data_wr_o(data_wr_o), .data_wr_en_o(data_wr_en_o)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic logic [71:0] mk(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d);
        return {c, a, d};
    endfunction

    // TCM stub: accept one clk after a request, ack on the following clk
    initial forever begin
        @(posedge clk);
        #1;
        mem_accept = 0;
        mem_ack = 0;
        if (rst) ack_due = 0;
        else if (ack_due) begin
            mem_ack = 1;
            data_rd_i = tcm.exists(ack_adr) ? tcm[ack_adr] : 32'h0;
            ack_due = 0;
        end else if (data_rd_en_o || data_wr_en_o != 4'h0) begin
            mem_accept = 1;
            reqs++;
            ack_adr = data_adr_o;
            if (data_wr_en_o == 4'hF) tcm[data_adr_o] = data_wr_o;
            ack_due = 1;
        end
    end

    // Scoreboard monitor: every completed host frame is checked against the oldest expectation
    initial forever begin
        logic [71:0] got;
        wait (cap_q.size() != 0);
        got = cap_q.pop_front();
        if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL miso_frame: got %h expected nothing", got);
        end else chk("miso_frame", got, exp_q.pop_front());
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    // Host: mode-0 SPI, LSB-first out on mosi, MSB-first capture of miso on rising edges
    task automatic send(input logic [71:0] f, input int n, input bit hold);
        logic [71:0] cap = 0;
        if (cs) begin
            cs = 0;
            repeat (2) @(negedge clk);
        end
        for (int i = 0; i < n; i++) begin
            mosi = f[i];
            #H sclk = 1;
            cap = {cap[70:0], miso};
            #H sclk = 0;
        end
        if (n == 72) cap_q.push_back(cap);
        if (!hold) begin
            #H cs = 1;
        end
        repeat (16) @(negedge clk);
    endtask

    // Full frame: expected capture is whatever the previous frames left in the reply
    task automatic full(input logic [71:0] f, input bit hold);
        logic [7:0] c = f[71:64];
        logic [31:0] a = f[63:32], d = f[31:0];
        exp_q.push_back(cur_tx);
        send(f, 72, hold);
        if (c == 8'hF0) begin
            ref_mem[a] = d;
            cur_tx = f;
        end else if (c == 8'h0F) cur_tx = mk(c, a, ref_mem.exists(a) ? ref_mem[a] : 32'h0);
        else if (c == 8'hFF) begin
            start_exp = 1;
            cur_tx = f;
        end else cur_tx = 0;
        chk("start_flag", 72'(start_flag), 72'(start_exp));
    endtask

    task automatic partial(input logic [71:0] f, input int n);
        send(f, n, 0);
        cur_tx = cur_tx << n;
    endtask

    initial begin
        int rq;
        logic [7:0] c;
        repeat (4) @(negedge clk);
        chk("rst_miso", 72'(miso), 0);
        chk("rst_start", 72'(start_flag), 0);
        chk("rst_rd_en", 72'(data_rd_en_o), 0);
        chk("rst_wr_en", 72'(data_wr_en_o), 0);
        chk("rst_adr", 72'(data_adr_o), 0);
        chk("rst_wr", 72'(data_wr_o), 0);
        rst = 0;
        repeat (4) @(negedge clk);

        full(mk(8'hF0, 32'h10, 32'h1140006F), 0);
        chk("write_tcm", 72'(tcm.exists(32'h10) ? tcm[32'h10] : 32'h0), 72'h1140006F);
        chk("write_adr", 72'(data_adr_o), 72'h10);
        chk("write_data", 72'(data_wr_o), 72'h1140006F);
        chk("write_en_released", 72'(data_wr_en_o), 0);
        full(mk(8'h0F, 32'h10, 32'h0), 0);
        chk("read_reply_model", cur_tx, 72'h0F000000101140006F);
        full(mk(8'h00, 32'h0, 32'h0), 0);

        full(mk(8'hFF, 32'h0, 32'h0), 0);

        rq = reqs;
        partial(mk(8'h0F, 32'h20, 32'hDEAD), 40);
        chk("abort_no_request", 72'(reqs), 72'(rq));
        full(mk(8'h0F, 32'h10, 32'h0), 0);
        chk("abort_one_request", 72'(reqs), 72'(rq + 1));

        full(mk(8'hF0, 32'h14, 32'hCAFEF00D), 1);
        full(mk(8'h0F, 32'h14, 32'h0), 1);
        full(mk(8'h12, 32'h0, 32'h0), 0);

        for (int k = 0; k < 30; k++) begin
            int r = $urandom_range(0, 9);
            c = r < 4 ? 8'hF0 : r < 8 ? 8'h0F : r == 8 ? 8'hFF : 8'($urandom_range(0, 255));
            if (r == 9 && (c == 8'hF0 || c == 8'h0F || c == 8'hFF)) c = 8'h5A;
            if ($urandom_range(0, 7) == 0) partial(mk(c, 32'($urandom_range(0, 7)) << 2, $urandom), $urandom_range(1, 71));
            full(mk(c, 32'($urandom_range(0, 7)) << 2, $urandom), 1'($urandom_range(0, 1)));
        end

        send(mk(8'h0F, 32'h10, 32'h0), 30, 1);
        #5 rst = 1;
        #1;
        chk("midrst_miso", 72'(miso), 0);
        chk("midrst_start", 72'(start_flag), 0);
        chk("midrst_rd_en", 72'(data_rd_en_o), 0);
        chk("midrst_wr_en", 72'(data_wr_en_o), 0);
        chk("midrst_adr", 72'(data_adr_o), 0);
        chk("midrst_wr", 72'(data_wr_o), 0);
        cs = 1;
        repeat (3) @(negedge clk);
        rst = 0;
        cur_tx = 0;
        start_exp = 0;
        repeat (4) @(negedge clk);
        full(mk(8'h0F, 32'h10, 32'h0), 0);
        full(mk(8'h00, 32'h0, 32'h0), 0);

        repeat (100) @(negedge clk);
        chk("scoreboard_drained", 72'(exp_q.size() + cap_q.size()), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
